// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: hex glyph table and slot states.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-high {g,f,e,d,c,b,a} glyphs, entry 15 (F) first down to entry 0.
  localparam logic [15:0][6:0] HEX_SEG_HI = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic {
    SLOT_BLANK = 1'b0,
    SLOT_DRIVE = 1'b1
  } slot_state_t;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Load-side and pin-side signals of the scan driver.
// Handshake: load_i is a 1-cycle strobe with no back-pressure; pending_o is high from
// the cycle after a load until the frame wrap that moves the captured data to the display.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] value_i;
  logic [NUM_DIGITS-1:0]   dp_i;
  logic [NUM_DIGITS-1:0]   digit_en_i;
  logic                    blank_lz_i;
  logic                    load_i;
  logic                    pending_o;
  logic                    frame_o;
  logic [NUM_DIGITS-1:0]   an_o;
  logic [6:0]              seg_o;
  logic                    dp_o;

  modport master (
    output value_i, dp_i, digit_en_i, blank_lz_i, load_i,
    input  pending_o, frame_o, an_o, seg_o, dp_o
  );

  modport slave (
    input  value_i, dp_i, digit_en_i, blank_lz_i, load_i,
    output pending_o, frame_o, an_o, seg_o, dp_o
  );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low segment pattern.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);
  assign seg = ~HEX_SEG_HI[nibble];
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with shadow/display double buffering,
// per-slot anti-ghosting blank and optional leading-zero suppression.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS      = 8,
  parameter int TICKS_PER_DIGIT = 100000,
  parameter int BLANK_TICKS     = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  seg7_scan_driver_if.slave bus,
  output slot_state_t  slot_state
);
  localparam int PW = $clog2(TICKS_PER_DIGIT);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_DIGIT - 1);
  localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_TICKS);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]         presc, presc_next;
  logic [IW-1:0]         idx;
  slot_state_t           state_q, state_d;
  logic                  presc_last, wrap;

  logic [VW-1:0]         shadow_value, disp_value;
  logic [NUM_DIGITS-1:0] shadow_dp, disp_dp, shadow_en, disp_en;
  logic                  shadow_lz, disp_lz;
  logic                  pending_q, frame_q;

  logic [NUM_DIGITS-1:0] an_d, an_q;
  logic [6:0]            seg_d, seg_q, cur_seg;
  logic                  dp_d, dp_q;

  logic [3:0]            cur_nib;
  logic                  cur_dp, cur_en, cur_lz, all_zero;
  logic [NUM_DIGITS-1:0] lz_mask;

  // Digit k is suppressed when it and every digit above it hold zero; digit 0 never is.
  always_comb begin
    lz_mask  = '0;
    all_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      all_zero   = all_zero && (disp_value[k*4 +: 4] == 4'h0);
      lz_mask[k] = disp_lz && all_zero;
    end
  end

  always_comb begin
    cur_nib = disp_value[3:0];
    cur_dp  = disp_dp[0];
    cur_en  = disp_en[0];
    cur_lz  = lz_mask[0];
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_nib = disp_value[k*4 +: 4];
        cur_dp  = disp_dp[k];
        cur_en  = disp_en[k];
        cur_lz  = lz_mask[k];
      end
    end
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (cur_nib),
    .seg    (cur_seg)
  );

  // Slot FSM next state plus next pin values; state_q tracks the current prescaler value.
  always_comb begin
    presc_last = (presc == PRESC_LAST);
    wrap       = presc_last && (idx == IDX_LAST);
    presc_next = presc_last ? '0 : presc + PW'(1);
    state_d    = (presc_next < BLANK_END) ? SLOT_BLANK : SLOT_DRIVE;
    an_d       = '1;
    seg_d      = SEG_OFF;
    dp_d       = 1'b1;
    if (state_q == SLOT_DRIVE) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        an_d[k] = ~((idx == IW'(k)) && cur_en);
      end
      seg_d = cur_lz ? SEG_OFF : cur_seg;
      dp_d  = ~(cur_dp && cur_en);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc        <= '0;
      idx          <= '0;
      state_q      <= SLOT_BLANK;
      shadow_value <= '0;
      shadow_dp    <= '0;
      shadow_en    <= '0;
      shadow_lz    <= 1'b0;
      disp_value   <= '0;
      disp_dp      <= '0;
      disp_en      <= '0;
      disp_lz      <= 1'b0;
      pending_q    <= 1'b0;
      frame_q      <= 1'b0;
      an_q         <= '1;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
    end else begin
      presc   <= presc_next;
      state_q <= state_d;
      if (presc_last) begin
        idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end
      frame_q <= wrap;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;

      // The wrap applies the shadow as it stood before this edge, so a same-cycle load stays pending.
      if (wrap && pending_q) begin
        disp_value <= shadow_value;
        disp_dp    <= shadow_dp;
        disp_en    <= shadow_en;
        disp_lz    <= shadow_lz;
      end
      if (bus.load_i) begin
        shadow_value <= bus.value_i;
        shadow_dp    <= bus.dp_i;
        shadow_en    <= bus.digit_en_i;
        shadow_lz    <= bus.blank_lz_i;
        pending_q    <= 1'b1;
      end else if (wrap) begin
        pending_q    <= 1'b0;
      end
    end
  end

  assign bus.pending_o = pending_q;
  assign bus.frame_o   = frame_q;
  assign bus.an_o      = an_q;
  assign bus.seg_o     = seg_q;
  assign bus.dp_o      = dp_q;
  assign slot_state    = state_q;

endmodule
